// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling, and stop-bit check.
// Each good byte produces a one-clock valid pulse. A low stop bit produces a one-clock framing-error pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LP_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [2:0]      r_bit_idx, w_bit_idx_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [7:0]      r_byte, w_byte_nxt;
  logic            r_dv, w_dv_nxt;
  logic            r_ferr, w_ferr_nxt;
  logic            r_sync1, r_sync2;
  logic            w_rx;

  assign w_rx = r_sync2;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_dv      <= 1'b0;
      r_ferr    <= 1'b0;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_byte    <= w_byte_nxt;
      r_dv      <= w_dv_nxt;
      r_ferr    <= w_ferr_nxt;
      r_sync1   <= i_Rx_Serial;
      r_sync2   <= r_sync1;
    end
  end

  // o_Rx_DV has no ready/back-pressure: it is a single-cycle strobe, and the consumer must take
  // o_Rx_Byte in that cycle. o_Rx_Byte then stays stable until the next good byte arrives.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_byte_nxt    = r_byte;
    w_dv_nxt      = 1'b0;
    w_ferr_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_count_nxt   = '0;
        w_bit_idx_nxt = '0;
        if (!w_rx) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_count == LP_MID) begin
          w_count_nxt = '0;
          w_state_nxt = w_rx ? S_IDLE : S_DATA;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      S_DATA: begin
        if (r_count == LP_LAST) begin
          w_count_nxt          = '0;
          w_shift_nxt[r_bit_idx] = w_rx;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      S_STOP: begin
        if (r_count == LP_LAST) begin
          w_count_nxt = '0;
          w_state_nxt = S_CLEANUP;
          if (w_rx) begin
            w_byte_nxt = r_shift;
            w_dv_nxt   = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      S_CLEANUP: begin
        // Wait for the line to go high so that a held-low break cannot re-trigger the receiver.
        if (w_rx) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_Rx_DV        = r_dv;
  assign o_Rx_Byte      = r_byte;
  assign o_Rx_Frame_Err = r_ferr;
  assign o_Rx_Active    = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. It drives 8N1 frames on the serial pin and checks every
// valid or framing-error event against an expected queue built from the frame contents.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       i_Reset;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Rx_Frame_Err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ev_cnt = 0;
  int dv_cyc[$];
  logic [8:0] exp_q[$];   // {frame_err, byte}
  logic [7:0] last_good;
  logic       prev_dv, prev_ferr;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         gap;
    logic       exp_ferr;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[7];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock       (clk),
    .i_Reset       (i_Reset),
    .i_Rx_Serial   (i_Rx_Serial),
    .o_Rx_DV       (o_Rx_DV),
    .o_Rx_Byte     (o_Rx_Byte),
    .o_Rx_Active   (o_Rx_Active),
    .o_Rx_Frame_Err(o_Rx_Frame_Err)
  );

  // Clock and reset.
  always #50 clk = ~clk;

  // Scoreboard: every DV/Frame_Err cycle is matched against the expected queue.
  initial begin
    prev_dv = 1'b0;
    prev_ferr = 1'b0;
  end

  always @(negedge clk) begin
    cyc++;
    if (!i_Reset) begin
      if (o_Rx_DV && o_Rx_Frame_Err) begin
        total++; bad++;
        $display("FAIL exclusive: dv=%0b ferr=%0b both high at cycle %0d", o_Rx_DV, o_Rx_Frame_Err, cyc);
      end
      if ((o_Rx_DV && prev_dv) || (o_Rx_Frame_Err && prev_ferr)) begin
        total++; bad++;
        $display("FAIL pulse_width: dv/ferr high for more than one clock at cycle %0d", cyc);
      end
      if (o_Rx_DV || o_Rx_Frame_Err) begin
        ev_cnt++;
        if (o_Rx_DV) dv_cyc.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got ferr=%0b byte=%02h, expected none", o_Rx_Frame_Err, o_Rx_Byte);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({o_Rx_Frame_Err, o_Rx_Byte} !== e) begin
            bad++;
            $display("FAIL event: got ferr=%0b byte=%02h, expected ferr=%0b byte=%02h",
                     o_Rx_Frame_Err, o_Rx_Byte, e[8], e[7:0]);
          end
        end
      end
    end
    prev_dv   = o_Rx_DV;
    prev_ferr = o_Rx_Frame_Err;
  end

  // Driver tasks.
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    i_Rx_Serial = b;
    wait_clks(CPB);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (stop_ok) begin
      send_bit(1'b1);
    end else begin
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
    end
  endtask

  // Reference model: a good stop bit delivers the data byte; a bad stop bit flags an error
  // while the held byte stays at the last good value.
  task automatic model_push(input logic [7:0] data, input logic stop_ok);
    if (stop_ok) begin
      exp_q.push_back({1'b0, data});
      last_good = data;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  initial begin
    int t0, act_cnt, ev0;
    i_Reset     = 1'b1;
    i_Rx_Serial = 1'b1;
    last_good   = 8'h00;
    vecs[0] = '{8'h00, 1'b1, 5,  1'b0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 0,  1'b0, 8'hFF};
    vecs[2] = '{8'hA5, 1'b1, 10, 1'b0, 8'hA5};
    vecs[3] = '{8'h5A, 1'b0, 0,  1'b1, 8'hA5};
    vecs[4] = '{8'h3C, 1'b1, 0,  1'b0, 8'h3C};
    vecs[5] = '{8'h81, 1'b1, 0,  1'b0, 8'h81};
    vecs[6] = '{8'h7E, 1'b1, 30, 1'b0, 8'h7E};
    wait_clks(5);
    check("reset_dv",     32'(o_Rx_DV),        32'h0);
    check("reset_byte",   32'(o_Rx_Byte),      32'h0);
    check("reset_active", 32'(o_Rx_Active),    32'h0);
    check("reset_ferr",   32'(o_Rx_Frame_Err), 32'h0);
    i_Reset = 1'b0;
    wait_clks(20);

    // Loopback-style 8'h63 then 8'h31 back to back: measure latency and spacing.
    dv_cyc.delete();
    model_push(8'h63, 1'b1);
    model_push(8'h31, 1'b1);
    i_Rx_Serial = 1'b0;
    t0 = cyc;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) send_bit(logic'(8'h63 >> i));
    send_bit(1'b1);
    send_frame(8'h31, 1'b1);
    wait_clks(100);
    check("b2b_dv_count", 32'(dv_cyc.size()), 32'd2);
    if (dv_cyc.size() == 2) begin
      check_range("dv_latency", dv_cyc[0] - t0, 820, 831);
      check_range("b2b_spacing", dv_cyc[1] - dv_cyc[0], 868, 872);
    end
    check("idle_active", 32'(o_Rx_Active), 32'h0);
    check("hold_byte", 32'(o_Rx_Byte), 32'h31);

    // Table-driven frames with hand-computed expectations.
    for (int v = 0; v < 7; v++) begin
      exp_q.push_back({vecs[v].exp_ferr, vecs[v].exp_byte});
      if (vecs[v].stop_ok) last_good = vecs[v].data;
      send_frame(vecs[v].data, vecs[v].stop_ok);
      wait_clks(vecs[v].gap);
      check("table_hold_byte", 32'(o_Rx_Byte), 32'(vecs[v].exp_byte));
    end
    wait_clks(50);

    // Glitch: 20 clocks low must not start a frame.
    ev0 = ev_cnt;
    act_cnt = 0;
    i_Rx_Serial = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (i == 20) i_Rx_Serial = 1'b1;
      @(negedge clk);
      if (o_Rx_Active) act_cnt++;
    end
    check_range("glitch_active", act_cnt, 1, 44);
    check("glitch_events", 32'(ev_cnt - ev0), 32'h0);
    check("glitch_idle", 32'(o_Rx_Active), 32'h0);

    // Reset during data bit 4 of 8'hF5; the upper bits stay high so nothing re-triggers.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(logic'(8'hF5 >> i));
    i_Rx_Serial = 1'b1;
    wait_clks(40);
    i_Reset = 1'b1;
    @(negedge clk);
    i_Reset = 1'b0;
    last_good = 8'h00;
    check("midrst_dv",     32'(o_Rx_DV),        32'h0);
    check("midrst_byte",   32'(o_Rx_Byte),      32'h0);
    check("midrst_active", 32'(o_Rx_Active),    32'h0);
    check("midrst_ferr",   32'(o_Rx_Frame_Err), 32'h0);
    wait_clks(CPB - 41);
    for (int i = 5; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    wait_clks(100);
    model_push(8'hC3, 1'b1);
    send_frame(8'hC3, 1'b1);
    wait_clks(20);
    check("after_reset_byte", 32'(o_Rx_Byte), 32'hC3);

    // Randomized frames, gaps and stop-bit corruption.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic ok;
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      model_push(d, ok);
      send_frame(d, ok);
      wait_clks($urandom_range(0, 60));
    end
    wait_clks(3 * CPB);

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #(100 * 90000);
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $finish;
  end

endmodule
